ksa_divider: RTL and testbench

Multi-cycle 32-bit integer divider built on a Kogge-Stone subtractor datapath; it is the inverse-operation companion to the 32-bit Kogge-Stone adder. It accepts a dividend/divisor pair over a valid/ready handshake, runs a restoring shift-subtract loop producing one quotient bit per cycle, and returns quotient and remainder over a second valid/ready handshake. It sits beside the adder as the arithmetic unit's divide path.

---
 rtl/ksa_pkg.sv | 16 +
 rtl/ksa_divider_if.sv | 53 +++++
 rtl/ksa_sub.sv | 44 ++++
 rtl/ksa_divider.sv | 170 +++++++++++++++++
 tb/tb_ksa_divider.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ksa_pkg.sv
// Shared definitions for the Kogge-Stone divide path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ksa_pkg;

  localparam int KSA_WIDTH = 32;

  localparam logic [KSA_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ksa_divider_if.sv
// Operand and result handshakes of the divider; is_signed only with KSA_DIV_SIGNED_EN.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both operand and result channels.
interface ksa_divider_if
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef KSA_DIV_SIGNED_EN
  logic             is_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
`ifdef KSA_DIV_SIGNED_EN
    output is_signed,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
`ifdef KSA_DIV_SIGNED_EN
    input  is_signed,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/ksa_sub.sv
// Kogge-Stone subtractor: diff = a - b computed as a + ~b + 1, no_borrow = carry-out.
// Latency: combinational.
// Backpressure: none.
module ksa_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  localparam int LV = $clog2(W);

  logic [W-1:0] bn;
  logic [W-1:0] p;
  logic [W-1:0] gk [LV+1];
  logic [W-1:0] pk [LV+1];

  assign bn = ~b;
  assign p  = a ^ bn;

  always_comb begin
    gk[0] = a & bn;
    // cin=1 folds into bit 0 as an unconditional generate when that bit propagates
    gk[0][0] = gk[0][0] | p[0];
    pk[0] = p;
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << l)) begin
          gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
          pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
        end else begin
          gk[l+1][i] = gk[l][i];
          pk[l+1][i] = pk[l][i];
        end
      end
    end
  end

  assign diff      = p ^ {gk[LV][W-2:0], 1'b1};
  assign no_borrow = gk[LV][W-1];

endmodule

// File: rtl/ksa_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle on a Kogge-Stone subtractor.
// Latency: 32 cycles from operand handshake to out_valid (1 cycle for a zero divisor).
// Backpressure: single operation in flight; in_ready low until the result handshake completes.
module ksa_divider
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  ksa_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_by_zero_r;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [CW-1:0]    cnt;
  logic             dbz_pend;
`ifdef KSA_DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
  logic             a_neg;
  logic             b_neg;
`endif

  logic [WIDTH:0]   t_val;
  logic [WIDTH:0]   d_val;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             unused_ok;

  assign accept = bus.in_valid && in_ready_r;

  assign t_val = {rem_r, dvd_r[WIDTH-1]};

  ksa_sub #(
    .W (WIDTH + 1)
  ) u_sub (
    .a         (t_val),
    .b         ({1'b0, dsr_r}),
    .diff      (d_val),
    .no_borrow (no_borrow)
  );

  // Whichever of D or T is kept is below the divisor, so its top bit is always zero.
  assign rem_nxt   = no_borrow ? d_val[WIDTH-1:0] : t_val[WIDTH-1:0];
  assign quo_nxt   = {dvd_r[WIDTH-2:0], no_borrow};
  assign unused_ok = &{1'b0, d_val[WIDTH]};

  always_comb begin
    a_mag = bus.dividend;
    b_mag = bus.divisor;
`ifdef KSA_DIV_SIGNED_EN
    a_neg = bus.is_signed && bus.dividend[WIDTH-1];
    b_neg = bus.is_signed && bus.divisor[WIDTH-1];
    if (a_neg) a_mag = -bus.dividend;
    if (b_neg) b_mag = -bus.divisor;
`endif
  end

`ifdef KSA_DIV_SIGNED_EN
  assign q_fin = neg_q ? -quo_nxt : quo_nxt;
  assign r_fin = neg_r ? -rem_nxt : rem_nxt;
`else
  assign q_fin = quo_nxt;
  assign r_fin = rem_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
      rem_r         <= '0;
      dvd_r         <= '0;
      dsr_r         <= '0;
      cnt           <= '0;
      dbz_pend      <= 1'b0;
`ifdef KSA_DIV_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_r    <= 1'b0;
            div_by_zero_r <= 1'b0;
            rem_r         <= '0;
            state         <= CALC;
            // A zero divisor spends one CALC cycle so its result appears one edge after acceptance.
            if (bus.divisor == '0) begin
              dbz_pend <= 1'b1;
              dvd_r    <= bus.dividend;
              cnt      <= '0;
            end else begin
              dbz_pend <= 1'b0;
              dvd_r    <= a_mag;
              dsr_r    <= b_mag;
              cnt      <= CW'(WIDTH - 1);
            end
`ifdef KSA_DIV_SIGNED_EN
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`endif
          end
        end

        CALC: begin
          if (dbz_pend) begin
            quotient_r    <= DIV0_QUOTIENT;
            remainder_r   <= dvd_r;
            div_by_zero_r <= 1'b1;
            out_valid_r   <= 1'b1;
            state         <= DONE;
          end else begin
            rem_r <= rem_nxt;
            dvd_r <= quo_nxt;
            cnt   <= cnt - 1'b1;
            if (cnt == '0) begin
              quotient_r  <= q_fin;
              remainder_r <= r_fin;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_ksa_divider.sv
// Directed and randomized checks of ksa_divider against an arithmetic reference model.
module tb_ksa_divider;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;

  ksa_divider_if bus ();

  ksa_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, signed semantics truncate toward zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic dbz);
    int   sa;
    int   sb;
    logic sgn;
    sgn = s;
`ifndef KSA_DIV_SIGNED_EN
    sgn = 1'b0;
`endif
    dbz = 1'b0;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dbz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.dividend = a;
    bus.divisor  = b;
`ifdef KSA_DIV_SIGNED_EN
    bus.is_signed = s;
`else
    if (s) bus.dividend = a;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ov_fall"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_ir_rise"}, {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ed;
    int          lat;
    model(a, b, s, eq, er, ed);
    start_op(a, b, s);
    wait_result(lat);
    check({tag, "_lat"}, lat, ed ? 32'd1 : 32'd32);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ed});
    check({tag, "_ir_busy"}, {31'd0, bus.in_ready}, 32'd0);
    release_result(tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          lat;
    int          pick;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
`ifdef KSA_DIV_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("u100_7", 32'd100, 32'd7, 1'b0);
    run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("u5_0", 32'd5, 32'd0, 1'b0);
`ifdef KSA_DIV_SIGNED_EN
    run_op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("s_div0", 32'hFFFF_FFF9, 32'd0, 1'b1);
`endif

    // Backpressure: result frozen while out_ready is low, even with new operands offered.
    start_op(32'd1000, 32'd10, 1'b0);
    wait_result(lat);
    check("bp_lat", lat, 32'd32);
    bus.dividend = 32'd77;
    bus.divisor  = 32'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_q", bus.quotient, 32'd100);
      check("bp_r", bus.remainder, 32'd0);
      check("bp_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      check("bp_ov", {31'd0, bus.out_valid}, 32'd1);
      check("bp_ir", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ir_rise", {31'd0, bus.in_ready}, 32'd1);
    check("bp_ov_fall", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of CALC discards the operation.
    start_op(32'd1000, 32'd7, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ir", {31'd0, bus.in_ready}, 32'd1);
    check("arst_ov", {31'd0, bus.out_valid}, 32'd0);
    check("arst_q", bus.quotient, 32'd0);
    check("arst_r", bus.remainder, 32'd0);
    check("arst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ov_after", {31'd0, bus.out_valid}, 32'd0);
    run_op("u9_3", 32'd9, 32'd3, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra   = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) rb = 32'd0;
      else if (pick < 5) rb = $urandom_range(1, 1000);
      else rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
